// File: rtl/value_capture.sv
// Falling-edge value capture register gated by a processor-step match.
// Define VALUE_CAPTURE_TRANSPARENT_EN for a transparent output while clock is high and the step matches.
module value_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] input_value,
    input  logic [1:0]       current_step,
    input  logic [1:0]       capture_on,
    output logic [WIDTH-1:0] captured_out
);

    logic [WIDTH-1:0] held;
    logic             match;

    assign match = (current_step == capture_on);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held <= '0;
        end else if (match) begin
            held <= input_value;
        end
    end

    always_comb begin
        captured_out = held;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        // Reset must win over transparency, so gate on reset_n as well as the high phase.
        if (reset_n && clock && match) begin
            captured_out = input_value;
        end
`endif
        if (!reset_n) begin
            captured_out = '0;
        end
    end

endmodule

// File: tb/tb_value_capture.sv
// Self-checking bench for value_capture: step-gating vector table plus transparency and reset sequences.
module tb_value_capture;

    logic        clock;
    logic        reset_n;
    logic [15:0] input_value;
    logic [1:0]  current_step;
    logic [1:0]  capture_on;
    logic [15:0] captured_out;

    int n_cmp = 0;
    int n_bad = 0;

    value_capture #(.WIDTH(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .input_value  (input_value),
        .current_step (current_step),
        .capture_on   (capture_on),
        .captured_out (captured_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  step;
        logic [1:0]  cap;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [15:0] exp);
        n_cmp++;
        if (captured_out !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, captured_out, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [1:0] s, input logic [1:0] c,
                           input logic [15:0] d, input logic [15:0] e);
        vecs[idx].step = s;
        vecs[idx].cap  = c;
        vecs[idx].din  = d;
        vecs[idx].exp  = e;
    endtask

    initial begin
        // Expected register value after the falling edge of each vector.
        set_vec(0,  2'd0, 2'd0, 16'h0000, 16'h0000);
        set_vec(1,  2'd1, 2'd0, 16'hFFFF, 16'h0000);
        set_vec(2,  2'd2, 2'd0, 16'hFFFF, 16'h0000);
        set_vec(3,  2'd3, 2'd0, 16'hFFFF, 16'h0000);
        set_vec(4,  2'd0, 2'd0, 16'hFFFF, 16'hFFFF);
        set_vec(5,  2'd0, 2'd1, 16'h0000, 16'hFFFF);
        set_vec(6,  2'd2, 2'd1, 16'h0000, 16'hFFFF);
        set_vec(7,  2'd3, 2'd1, 16'h0000, 16'hFFFF);
        set_vec(8,  2'd1, 2'd1, 16'h0000, 16'h0000);
        set_vec(9,  2'd0, 2'd2, 16'hFFFF, 16'h0000);
        set_vec(10, 2'd1, 2'd2, 16'hFFFF, 16'h0000);
        set_vec(11, 2'd3, 2'd2, 16'hFFFF, 16'h0000);
        set_vec(12, 2'd2, 2'd2, 16'hFFFF, 16'hFFFF);
        set_vec(13, 2'd0, 2'd3, 16'h0000, 16'hFFFF);
        set_vec(14, 2'd1, 2'd3, 16'h0000, 16'hFFFF);
        set_vec(15, 2'd2, 2'd3, 16'h0000, 16'hFFFF);
        set_vec(16, 2'd3, 2'd3, 16'h0000, 16'h0000);

        reset_n      = 1'b0;
        input_value  = 16'h0000;
        current_step = 2'd0;
        capture_on   = 2'd0;
        #2;
        check("reset_state", 16'h0000);
        @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clock); #1;
            current_step = vecs[i].step;
            capture_on   = vecs[i].cap;
            input_value  = vecs[i].din;
            @(negedge clock); #2;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Transparency sequence; register holds 0000 here.
        @(posedge clock); #1;
        current_step = 2'd3;
        capture_on   = 2'd3;
        input_value  = 16'hEEEE;
        #1;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        check("transp_eeee", 16'hEEEE);
`else
        check("opaque_eeee", 16'h0000);
`endif
        input_value = 16'h4242;
        #1;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        check("transp_4242", 16'h4242);
`else
        check("opaque_4242", 16'h0000);
`endif
        @(negedge clock); #1;
        check("capture_4242", 16'h4242);
        input_value = 16'hFFFF;
        #1;
        check("low_hold_4242", 16'h4242);
        @(posedge clock); #1;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        check("high_match_ffff", 16'hFFFF);
`else
        check("high_match_hold", 16'h4242);
`endif
        capture_on = 2'd0;
        #1;
        check("high_nomatch_hold", 16'h4242);
        @(negedge clock); #1;
        check("fall_nomatch_hold", 16'h4242);

        // Asynchronous reset during a matching high phase.
        @(posedge clock); #1;
        current_step = 2'd1;
        capture_on   = 2'd1;
        input_value  = 16'h1234;
        #1;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        check("pre_reset_transp", 16'h1234);
`else
        check("pre_reset_hold", 16'h4242);
`endif
        reset_n = 1'b0;
        #1;
        check("reset_high_phase", 16'h0000);
        @(negedge clock); #1;
        check("reset_fall_nocap", 16'h0000);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
`ifdef VALUE_CAPTURE_TRANSPARENT_EN
        check("release_transp", 16'h1234);
`else
        check("release_hold", 16'h0000);
`endif
        @(negedge clock); #1;
        check("first_capture", 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
